// File: rtl/midi_pkg.sv
// Shared MIDI constants and the voice-allocator FSM state encoding.
package midi_pkg;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] CC       = 4'hB;

  localparam logic [6:0] CC_SUSTAIN       = 7'd64;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SCAN,
    S_COMMIT,
    S_RETRIG,
    S_ACK
  } state_t;
endpackage

// File: rtl/midi_voice_allocator_if.sv
// Event valid/ack handshake from the MIDI receiver to the voice allocator.
interface midi_voice_allocator_if;
  logic       midi_event_valid;
  logic [7:0] midi_command;
  logic [6:0] midi_parameter_1;
  logic [6:0] midi_parameter_2;
  logic       midi_event_ack;

  modport master (output midi_event_valid, midi_command, midi_parameter_1,
                  midi_parameter_2, input midi_event_ack);
  modport slave  (input midi_event_valid, midi_command, midi_parameter_1,
                  midi_parameter_2, output midi_event_ack);
endinterface

// File: rtl/midi_voice_allocator_age_tracker.sv
// Per-voice allocation stamps plus a one-voice-per-cycle search for the oldest
// held voice; age is modular so stamp counter wrap does not misorder voices.
module voice_age_tracker #(
  parameter int NUM_VOICES = 8,
  parameter int STAMP_BITS = 16,
  parameter int IDX_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_scan_clr,
  input  logic             i_scan_en,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_cand,
  input  logic             i_commit,
  input  logic [IDX_W-1:0] i_commit_idx,
  output logic [IDX_W-1:0] o_oldest_idx,
  output logic             o_oldest_vld
);
  logic [STAMP_BITS-1:0] r_stamp [NUM_VOICES];
  logic [STAMP_BITS-1:0] r_ctr;
  logic [STAMP_BITS-1:0] r_best_age;
  logic [STAMP_BITS-1:0] w_age;
  logic [IDX_W-1:0]      r_oldest_idx;
  logic                  r_oldest_vld;

  assign w_age        = r_ctr - r_stamp[i_idx];
  assign o_oldest_idx = r_oldest_idx;
  assign o_oldest_vld = r_oldest_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) r_stamp[i] <= '0;
      r_ctr        <= '0;
      r_best_age   <= '0;
      r_oldest_idx <= '0;
      r_oldest_vld <= 1'b0;
    end else begin
      // strict '>' keeps the lowest index on equal ages since the scan ascends
      if (i_scan_clr) begin
        r_oldest_vld <= 1'b0;
      end else if (i_scan_en && i_cand && (!r_oldest_vld || w_age > r_best_age)) begin
        r_best_age   <= w_age;
        r_oldest_idx <= i_idx;
        r_oldest_vld <= 1'b1;
      end
      if (i_commit) begin
        r_stamp[i_commit_idx] <= r_ctr;
        r_ctr                 <= r_ctr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: channel filter, velocity capture, oldest-voice
// stealing with gate retrigger, sustain pedal and all-notes-off.
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES       = 8,
  parameter int STAMP_BITS       = 16,
  parameter int RETRIGGER_CYCLES = 800
) (
  input  logic                    clk,
  input  logic                    rst_n,
  midi_voice_allocator_if.slave   bus,
  input  logic [3:0]              midi_channel,
  input  logic                    omni,
  input  logic [NUM_VOICES-1:0]   voice_idle,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic                    busy
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int RC_W  = $clog2(RETRIGGER_CYCLES + 1);
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_VOICES - 1);

  state_t r_state, w_next;
  logic [7:0] r_cmd;
  logic [6:0] r_p1, r_p2;
  idx_t r_idx, r_tgt, w_tgt, w_oldest_idx;
  idx_t r_match_idx, r_idle_idx, r_free_idx;
  logic r_match_vld, r_idle_vld, r_free_vld, w_oldest_vld;
  logic r_is_on, r_sustain, w_steal;
  logic w_chan_ok, w_is_on, w_is_off, w_is_cc;
  logic [NUM_VOICES-1:0] r_gate, r_held, r_sus;
  logic [6:0] r_note [NUM_VOICES];
  logic [6:0] r_vel  [NUM_VOICES];
  logic [RC_W-1:0] r_rcnt;

  assign w_chan_ok = omni || (r_cmd[3:0] == midi_channel);
  assign w_is_on   = (r_cmd[7:4] == NOTE_ON) && (r_p2 != 7'd0);
  assign w_is_off  = (r_cmd[7:4] == NOTE_OFF) || ((r_cmd[7:4] == NOTE_ON) && (r_p2 == 7'd0));
  assign w_is_cc   = (r_cmd[7:4] == CC);

  voice_age_tracker #(
    .NUM_VOICES(NUM_VOICES), .STAMP_BITS(STAMP_BITS), .IDX_W(IDX_W)
  ) u_age (
    .clk(clk), .rst_n(rst_n),
    .i_scan_clr(r_state == S_DECODE), .i_scan_en(r_state == S_SCAN),
    .i_idx(r_idx), .i_cand(r_held[r_idx]),
    .i_commit(r_state == S_COMMIT), .i_commit_idx(w_tgt),
    .o_oldest_idx(w_oldest_idx), .o_oldest_vld(w_oldest_vld)
  );

  // With no held voice and no idle one, the first non-held (still releasing) voice is reused.
  always_comb begin
    w_tgt   = '0;
    w_steal = 1'b1;
    if (r_match_vld) begin
      w_tgt = r_match_idx;
    end else if (r_idle_vld) begin
      w_tgt   = r_idle_idx;
      w_steal = 1'b0;
    end else if (w_oldest_vld) begin
      w_tgt = w_oldest_idx;
    end else if (r_free_vld) begin
      w_tgt = r_free_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.midi_event_valid) w_next = S_DECODE;
      S_DECODE: w_next = (w_chan_ok && (w_is_on || w_is_off)) ? S_SCAN : S_ACK;
      S_SCAN:   if (r_idx == LAST_IDX) w_next = r_is_on ? S_COMMIT : S_ACK;
      S_COMMIT: w_next = w_steal ? S_RETRIG : S_ACK;
      S_RETRIG: if (r_rcnt == '0) w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0; r_p1 <= '0; r_p2 <= '0;
      r_idx <= '0; r_tgt <= '0; r_rcnt <= '0;
      r_is_on <= 1'b0; r_sustain <= 1'b0;
      r_match_vld <= 1'b0; r_idle_vld <= 1'b0; r_free_vld <= 1'b0;
      r_match_idx <= '0; r_idle_idx <= '0; r_free_idx <= '0;
      r_gate <= '0; r_held <= '0; r_sus <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= '0;
        r_vel[i]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: if (bus.midi_event_valid) begin
          r_cmd <= bus.midi_command;
          r_p1  <= bus.midi_parameter_1;
          r_p2  <= bus.midi_parameter_2;
        end
        S_DECODE: begin
          r_idx       <= '0;
          r_is_on     <= w_is_on;
          r_match_vld <= 1'b0;
          r_idle_vld  <= 1'b0;
          r_free_vld  <= 1'b0;
          if (w_chan_ok && w_is_cc) begin
            if (r_p1 == CC_SUSTAIN) begin
              r_sustain <= r_p2[6];
              if (r_sustain && !r_p2[6]) begin
                r_gate <= r_gate & ~r_sus;
                r_held <= r_held & ~r_sus;
                r_sus  <= '0;
              end
            end else if (r_p1 == CC_ALL_NOTES_OFF) begin
              r_gate <= '0;
              r_held <= '0;
              r_sus  <= '0;
            end
          end
        end
        S_SCAN: begin
          r_idx <= r_idx + idx_t'(1);
          if (r_is_on) begin
            if (!r_match_vld && r_held[r_idx] && r_note[r_idx] == r_p1) begin
              r_match_vld <= 1'b1;
              r_match_idx <= r_idx;
            end
            if (!r_idle_vld && voice_idle[r_idx] && !r_held[r_idx]) begin
              r_idle_vld <= 1'b1;
              r_idle_idx <= r_idx;
            end
            if (!r_free_vld && !r_held[r_idx]) begin
              r_free_vld <= 1'b1;
              r_free_idx <= r_idx;
            end
          end else if (r_held[r_idx] && r_note[r_idx] == r_p1) begin
            if (r_sustain) begin
              r_sus[r_idx] <= 1'b1;
            end else begin
              r_gate[r_idx] <= 1'b0;
              r_held[r_idx] <= 1'b0;
            end
          end
        end
        S_COMMIT: begin
          r_note[w_tgt] <= r_p1;
          r_vel[w_tgt]  <= r_p2;
          r_held[w_tgt] <= 1'b1;
          r_sus[w_tgt]  <= 1'b0;
          r_gate[w_tgt] <= !w_steal;
          r_tgt         <= w_tgt;
          r_rcnt        <= RC_W'(RETRIGGER_CYCLES - 1);
        end
        S_RETRIG: begin
          if (r_rcnt == '0) r_gate[r_tgt] <= 1'b1;
          else              r_rcnt <= r_rcnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[7*g +: 7]     = r_note[g];
    assign voice_velocity[7*g +: 7] = r_vel[g];
  end

  assign voice_gate         = r_gate;
  assign bus.midi_event_ack = (r_state == S_ACK);
  assign busy               = (r_state != S_IDLE);
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Randomised bench for midi_voice_allocator against an event-level voice model.
module tb_midi_voice_allocator;
  localparam int N = 8;
  localparam int R = 800;
  localparam int LIMIT = N + R + 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] midi_channel = 4'd0;
  logic omni = 1'b1;
  logic [N-1:0] vidle = '1;
  logic [N-1:0] voice_gate;
  logic [7*N-1:0] voice_note, voice_velocity;
  logic busy;
  int n_vec = 0;
  int n_err = 0;

  midi_voice_allocator_if bus();

  midi_voice_allocator #(.NUM_VOICES(N), .STAMP_BITS(16), .RETRIGGER_CYCLES(R)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .midi_channel(midi_channel), .omni(omni), .voice_idle(vidle),
    .voice_gate(voice_gate), .voice_note(voice_note),
    .voice_velocity(voice_velocity), .busy(busy)
  );

  always #31 clk = ~clk;

  // reference voice state; age is an ever-increasing allocation serial number
  bit m_gate[N], m_held[N], m_sus[N];
  int m_note[N], m_vel[N], m_serial[N];
  int m_next_serial;
  bit m_sustain;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_gate[v] = 0; m_held[v] = 0; m_sus[v] = 0;
      m_note[v] = 0; m_vel[v] = 0; m_serial[v] = 0;
    end
    m_next_serial = 0;
    m_sustain = 0;
  endtask

  task automatic model_apply(input logic [7:0] c, input int p1, input int p2,
                             output int lat, output int tgt, output bit chk_low);
    int match, free, old, spare;
    bit steal, is_on, is_off;
    lat = 3; tgt = -1; chk_low = 0;
    if (!(omni || c[3:0] == midi_channel)) return;
    if (c[7:4] == 4'hB) begin
      if (p1 == 64) begin
        if (m_sustain && p2 < 64)
          for (int v = 0; v < N; v++)
            if (m_sus[v]) begin m_gate[v] = 0; m_held[v] = 0; m_sus[v] = 0; end
        m_sustain = (p2 >= 64);
      end else if (p1 == 123) begin
        for (int v = 0; v < N; v++) begin m_gate[v] = 0; m_held[v] = 0; m_sus[v] = 0; end
      end
      return;
    end
    is_on  = (c[7:4] == 4'h9) && p2 != 0;
    is_off = (c[7:4] == 4'h8) || ((c[7:4] == 4'h9) && p2 == 0);
    if (is_off) begin
      lat = N + 3;
      for (int v = 0; v < N; v++)
        if (m_held[v] && m_note[v] == p1) begin
          if (m_sustain) m_sus[v] = 1;
          else begin m_gate[v] = 0; m_held[v] = 0; end
        end
      return;
    end
    if (!is_on) return;
    lat = N + 4;
    match = -1; free = -1; old = -1; spare = -1;
    for (int v = 0; v < N; v++) begin
      if (match < 0 && m_held[v] && m_note[v] == p1) match = v;
      if (free < 0 && vidle[v] && !m_held[v]) free = v;
      if (spare < 0 && !m_held[v]) spare = v;
      if (m_held[v] && (old < 0 || m_serial[v] < m_serial[old])) old = v;
    end
    steal = 1;
    if (match >= 0) tgt = match;
    else if (free >= 0) begin tgt = free; steal = 0; end
    else if (old >= 0) tgt = old;
    else tgt = spare;
    chk_low = steal && m_gate[tgt];
    if (steal) lat += R;
    m_note[tgt] = p1; m_vel[tgt] = p2; m_held[tgt] = 1; m_sus[tgt] = 0;
    m_gate[tgt] = 1; m_serial[tgt] = m_next_serial++;
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg;
    logic [7*N-1:0] en, ev;
    for (int v = 0; v < N; v++) begin
      eg[v] = m_gate[v];
      en[7*v +: 7] = 7'(m_note[v]);
      ev[7*v +: 7] = 7'(m_vel[v]);
    end
    check({tag, "_gate"}, 64'(voice_gate), 64'(eg));
    check({tag, "_note"}, 64'(voice_note), 64'(en));
    check({tag, "_vel"}, 64'(voice_velocity), 64'(ev));
  endtask

  task automatic send(input string tag, input logic [7:0] c, input int p1, input int p2);
    int lat, tgt, cyc, low;
    bit chk_low, seen;
    model_apply(c, p1, p2, lat, tgt, chk_low);
    @(negedge clk);
    bus.midi_event_valid = 1'b1;
    bus.midi_command     = c;
    bus.midi_parameter_1 = 7'(p1);
    bus.midi_parameter_2 = 7'(p2);
    cyc = 1; low = 0; seen = 0;
    while (!seen && cyc <= LIMIT) begin
      @(negedge clk);
      cyc++;
      if (tgt >= 0 && !voice_gate[tgt]) low++;
      seen = bus.midi_event_ack;
    end
    bus.midi_event_valid = 1'b0;
    check({tag, "_ack_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    if (chk_low) check({tag, "_retrig_low"}, 64'(low), 64'(R));
    check_outputs(tag);
    @(negedge clk);
    check({tag, "_ack_pulse"}, 64'(bus.midi_event_ack), 64'd0);
    check({tag, "_busy_clr"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [7:0] c;
    int p1, p2, sel;
    bit seen;
    bus.midi_event_valid = 1'b0;
    bus.midi_command = '0;
    bus.midi_parameter_1 = '0;
    bus.midi_parameter_2 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_gate", 64'(voice_gate), 64'd0);
    check("rst_note", 64'(voice_note), 64'd0);
    check("rst_vel", 64'(voice_velocity), 64'd0);
    check("rst_ack", 64'(bus.midi_event_ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // first note lands on voice 0
    send("on60", 8'h90, 60, 100);
    check("on60_v0_gate", 64'(voice_gate[0]), 64'd1);
    check("on60_v0_note", 64'(voice_note[6:0]), 64'd60);
    check("on60_v0_vel", 64'(voice_velocity[6:0]), 64'd100);
    send("off60", 8'h80, 60, 0);
    check("off60_v0_gate", 64'(voice_gate[0]), 64'd0);
    send("on60b", 8'h90, 60, 90);
    send("on60v0", 8'h90, 60, 0);
    check("on60v0_v0_gate", 64'(voice_gate[0]), 64'd0);

    // fill all voices, then steal the oldest
    send("clr", 8'hB0, 123, 0);
    for (int v = 0; v < N; v++) send("fill", 8'h90, 60 + v, 50 + v);
    vidle = '0;
    send("steal", 8'h90, 70, 33);
    check("steal_v0_note", 64'(voice_note[6:0]), 64'd70);
    check("steal_v0_gate", 64'(voice_gate[0]), 64'd1);

    // sustain pedal
    send("clr2", 8'hB0, 123, 0);
    vidle = '1;
    send("s_on", 8'h90, 60, 64);
    send("ped_dn", 8'hB0, 64, 127);
    send("s_off", 8'h80, 60, 0);
    check("sus_hold_gate", 64'(voice_gate[0]), 64'd1);
    send("ped_up", 8'hB0, 64, 0);
    check("sus_rel_gate", 64'(voice_gate[0]), 64'd0);

    // channel filtering and all-notes-off
    omni = 1'b0; midi_channel = 4'd2;
    send("wrongch", 8'h95, 61, 80);
    check("wrongch_gates", 64'(voice_gate), 64'd0);
    for (int v = 0; v < 3; v++) send("ch2", 8'h92, 40 + v, 70);
    check("ch2_gates", 64'(voice_gate), 64'h7);
    send("ano", 8'hB2, 123, 0);
    check("ano_gates", 64'(voice_gate), 64'd0);

    // randomised traffic
    for (int k = 0; k < 60; k++) begin
      omni = ($urandom_range(0, 3) != 0);
      c[3:0] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd2;
      vidle = N'($urandom);
      p1 = $urandom_range(60, 69);
      p2 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
      sel = $urandom_range(0, 9);
      if (sel < 5) c[7:4] = 4'h9;
      else if (sel < 7) c[7:4] = 4'h8;
      else if (sel == 9) c[7:4] = ($urandom_range(0, 1) != 0) ? 4'hA : 4'hE;
      else begin
        c[7:4] = 4'hB;
        p1 = (sel == 8 && $urandom_range(0, 2) == 0) ? 123 : 64;
      end
      send("rnd", c, p1, p2);
    end

    // reset in the middle of a retrigger
    omni = 1'b1;
    send("clr3", 8'hB0, 123, 0);
    vidle = '1;
    for (int v = 0; v < N; v++) send("fill2", 8'h90, 40 + v, 20);
    vidle = '0;
    @(negedge clk);
    bus.midi_event_valid = 1'b1;
    bus.midi_command = 8'h90;
    bus.midi_parameter_1 = 7'd50;
    bus.midi_parameter_2 = 7'd99;
    seen = 0;
    repeat (N + 10) begin
      @(negedge clk);
      seen |= bus.midi_event_ack;
    end
    check("abort_busy", 64'(busy), 64'd1);
    check("abort_noack", 64'(seen), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_gate", 64'(voice_gate), 64'd0);
    check("abort_note", 64'(voice_note), 64'd0);
    check("abort_busy_clr", 64'(busy), 64'd0);
    check("abort_ack", 64'(bus.midi_event_ack), 64'd0);
    bus.midi_event_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    vidle = '1;
    send("post_rst", 8'h90, 61, 77);
    check("post_rst_v0_note", 64'(voice_note[6:0]), 64'd61);
    check("post_rst_v0_gate", 64'(voice_gate[0]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
